// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-lite IRAM responder.
// Both the bus-facing FSMs and the backing RAM import these definitions.
package axi4_lite_pkg;

  localparam int PROT_W = 3;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_RESP  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/ram_sdp_be.sv
// Simple dual-port word RAM with per-byte write enables and a registered read port.
// A read and a write to the same word on the same edge return the old contents.
module ram_sdp_be
  import axi4_lite_pkg::*;
#(
  parameter int DEPTH  = 32768,
  parameter int DWIDTH = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem_r [DEPTH];
  logic [DWIDTH-1:0] rdata_r;

  // Byte-enabled write port; non-blocking update gives read-before-write
  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (we && wstrb[b]) begin
        mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Synchronous read port
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/axi4_lite_ram_responder.sv
// AXI4-lite responder in front of the on-chip IRAM: independent write and read FSMs.
// Every handshake output is a flop so the interconnect sees no input-to-output path.
module axi4_lite_ram_responder
  import axi4_lite_pkg::*;
#(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int DEPTH_WORDS = 32768
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              awvalid,
  output logic              awready,
  input  logic [AWIDTH-1:0] awaddr,
  input  logic [PROT_W-1:0] awprot,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic              bvalid,
  input  logic              bready,
  input  logic              arvalid,
  output logic              arready,
  input  logic [AWIDTH-1:0] araddr,
  input  logic [PROT_W-1:0] arprot,
  output logic              rvalid,
  input  logic              rready,
  output logic [DWIDTH-1:0] rdata
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  wr_state_t         wr_state_r, wr_next_s;
  rd_state_t         rd_state_r, rd_next_s;
  logic              awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
  logic [DWIDTH-1:0] rdata_r, ram_q_s;
  logic [IDX_W-1:0]  wr_idx_r, rd_idx_r, aw_idx_s, ar_idx_s, cm_idx_s;
  logic [DWIDTH-1:0] wr_data_r, cm_data_s;
  logic [STRB_W-1:0] wr_strb_r, cm_strb_s;
  logic              aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, commit_s, ram_we_s, ram_re_s;
  logic              unused_s;

  assign aw_idx_s = awaddr[IDX_W+1:2];
  assign ar_idx_s = araddr[IDX_W+1:2];
  assign unused_s = ^{awprot, arprot, awaddr[AWIDTH-1:IDX_W+2], awaddr[1:0],
                      araddr[AWIDTH-1:IDX_W+2], araddr[1:0]};

  assign aw_hs_s = awvalid & awready_r;
  assign w_hs_s  = wvalid & wready_r;
  assign b_hs_s  = bvalid_r & bready;
  assign ar_hs_s = arvalid & arready_r;
  assign r_hs_s  = rvalid_r & rready;

  // Write FSM next state and commit source: whichever half arrived earlier comes from the latch
  always_comb begin
    wr_next_s = wr_state_r;
    commit_s  = 1'b0;
    cm_idx_s  = aw_idx_s;
    cm_data_s = wdata;
    cm_strb_s = wstrb;
    case (wr_state_r)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          commit_s  = 1'b1;
          wr_next_s = W_RESP;
        end else if (aw_hs_s) begin
          wr_next_s = W_HAVE_A;
        end else if (w_hs_s) begin
          wr_next_s = W_HAVE_D;
        end else begin
          wr_next_s = W_IDLE;
        end
      end
      W_HAVE_A: begin
        cm_idx_s = wr_idx_r;
        if (w_hs_s) begin
          commit_s  = 1'b1;
          wr_next_s = W_RESP;
        end else begin
          wr_next_s = W_HAVE_A;
        end
      end
      W_HAVE_D: begin
        cm_data_s = wr_data_r;
        cm_strb_s = wr_strb_r;
        if (aw_hs_s) begin
          commit_s  = 1'b1;
          wr_next_s = W_RESP;
        end else begin
          wr_next_s = W_HAVE_D;
        end
      end
      W_RESP: begin
        if (b_hs_s) begin
          wr_next_s = W_IDLE;
        end else begin
          wr_next_s = W_RESP;
        end
      end
      default: wr_next_s = W_IDLE;
    endcase
  end

  // Write state, latches and registered ready/valid outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_r <= W_IDLE;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      wr_idx_r   <= {IDX_W{1'b0}};
      wr_data_r  <= {DWIDTH{1'b0}};
      wr_strb_r  <= {STRB_W{1'b0}};
    end else begin
      wr_state_r <= wr_next_s;
      awready_r  <= (wr_next_s == W_IDLE) || (wr_next_s == W_HAVE_D);
      wready_r   <= (wr_next_s == W_IDLE) || (wr_next_s == W_HAVE_A);
      bvalid_r   <= (wr_next_s == W_RESP);
      if (aw_hs_s) begin
        wr_idx_r <= aw_idx_s;
      end
      if (w_hs_s) begin
        wr_data_r <= wdata;
        wr_strb_r <= wstrb;
      end
    end
  end

  // Read FSM next state
  always_comb begin
    rd_next_s = rd_state_r;
    case (rd_state_r)
      R_IDLE:  rd_next_s = ar_hs_s ? R_FETCH : R_IDLE;
      R_FETCH: rd_next_s = R_RESP;
      R_RESP:  rd_next_s = r_hs_s ? R_IDLE : R_RESP;
      default: rd_next_s = R_IDLE;
    endcase
  end

  // Read state and output registers; rdata is captured from the RAM one cycle after the fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_r <= R_IDLE;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= {DWIDTH{1'b0}};
      rd_idx_r   <= {IDX_W{1'b0}};
    end else begin
      rd_state_r <= rd_next_s;
      arready_r  <= (rd_next_s == R_IDLE);
      if (ar_hs_s) begin
        rd_idx_r <= ar_idx_s;
      end
      if (r_hs_s) begin
        rvalid_r <= 1'b0;
      end else if ((rd_state_r == R_RESP) && !rvalid_r) begin
        rvalid_r <= 1'b1;
        rdata_r  <= ram_q_s;
      end
    end
  end

  // A write completing on the reset edge is dropped
  assign ram_we_s = commit_s & ~reset;
  assign ram_re_s = (rd_state_r == R_FETCH);

  ram_sdp_be #(
    .DEPTH  (DEPTH_WORDS),
    .DWIDTH (DWIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (cm_idx_s),
    .wdata (cm_data_s),
    .wstrb (cm_strb_s),
    .re    (ram_re_s),
    .raddr (rd_idx_r),
    .rdata (ram_q_s)
  );

  assign awready = awready_r;
  assign wready  = wready_r;
  assign bvalid  = bvalid_r;
  assign arready = arready_r;
  assign rvalid  = rvalid_r;
  assign rdata   = rdata_r;

endmodule

// File: tb/tb_axi4_lite_ram_responder.sv
// Randomised self-checking bench for axi4_lite_ram_responder against a word-array reference model.
module tb_axi4_lite_ram_responder;

  localparam int DEPTH = 32768;

  logic        clk = 1'b0;
  logic        reset;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;

  int checks   = 0;
  int failures = 0;
  logic [31:0] ref_mem [int];

  axi4_lite_ram_responder dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic get_rdy(input int which);
    if (which == 0) return awready;
    else if (which == 1) return wready;
    else return arready;
  endfunction

  task automatic wait_rdy(input int which, input string tag);
    int n = 0;
    while (get_rdy(which) !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_eq({tag, "_ready_wait"}, {31'd0, get_rdy(which)}, 32'd1);
  endtask

  // mode 0: AW+W together, 1: AW first, 2: W first; gap = idle cycles between halves
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int mode, input int gap, input int bdelay, input string tag);
    int idx = widx(addr);
    logic [31:0] old;
    awaddr = addr; wdata = data; wstrb = strb; awprot = 3'($urandom);
    if (mode == 0) begin
      awvalid = 1'b1; wvalid = 1'b1;
      wait_rdy(0, tag);
      check_eq({tag, "_wready_idle"}, {31'd0, wready}, 32'd1);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
    end else if (mode == 1) begin
      awvalid = 1'b1;
      wait_rdy(0, tag);
      tick();
      awvalid = 1'b0;
      check_eq({tag, "_awready_after_aw"}, {31'd0, awready}, 32'd0);
      check_eq({tag, "_wready_after_aw"}, {31'd0, wready}, 32'd1);
      repeat (gap) tick();
      wvalid = 1'b1;
      wait_rdy(1, tag);
      tick();
      wvalid = 1'b0;
    end else begin
      wvalid = 1'b1;
      wait_rdy(1, tag);
      tick();
      wvalid = 1'b0;
      check_eq({tag, "_wready_after_w"}, {31'd0, wready}, 32'd0);
      check_eq({tag, "_awready_after_w"}, {31'd0, awready}, 32'd1);
      repeat (gap) tick();
      awvalid = 1'b1;
      wait_rdy(0, tag);
      tick();
      awvalid = 1'b0;
    end
    check_eq({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
    repeat (bdelay) begin
      tick();
      check_eq({tag, "_bvalid_hold"}, {31'd0, bvalid}, 32'd1);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check_eq({tag, "_bvalid_clear"}, {31'd0, bvalid}, 32'd0);
    old = ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) old[b*8 +: 8] = data[b*8 +: 8];
    end
    ref_mem[idx] = old;
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold, input string tag);
    logic [31:0] exp = ref_mem[widx(addr)];
    araddr = addr; arprot = 3'($urandom); arvalid = 1'b1;
    wait_rdy(2, tag);
    tick();
    arvalid = 1'b0;
    check_eq({tag, "_rvalid_n1"}, {31'd0, rvalid}, 32'd0);
    tick();
    check_eq({tag, "_rvalid_n2"}, {31'd0, rvalid}, 32'd0);
    tick();
    check_eq({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    check_eq({tag, "_rdata"}, rdata, exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      check_eq({tag, "_rvalid_hold"}, {31'd0, rvalid}, 32'd1);
      check_eq({tag, "_rdata_hold"}, rdata, exp);
      check_eq({tag, "_arready_hold"}, {31'd0, arready}, 32'd0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check_eq({tag, "_rvalid_clear"}, {31'd0, rvalid}, 32'd0);
    check_eq({tag, "_arready_back"}, {31'd0, arready}, 32'd1);
  endtask

  initial begin
    logic [31:0] v_old, v_new, a;
    reset = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    awaddr = 32'd0; wdata = 32'd0; wstrb = 4'd0; araddr = 32'd0; awprot = 3'd0; arprot = 3'd0;
    tick(); tick();
    check_eq("rst_awready", {31'd0, awready}, 32'd0);
    check_eq("rst_arready", {31'd0, arready}, 32'd0);
    check_eq("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check_eq("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    tick();
    check_eq("idle_awready", {31'd0, awready}, 32'd1);
    check_eq("idle_wready", {31'd0, wready}, 32'd1);
    check_eq("idle_arready", {31'd0, arready}, 32'd1);

    do_write(32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, "wr_same");
    do_read(32'h0000_0040, 0, "rd_same");
    do_write(32'h0000_0040, 32'h1122_3344, 4'h5, 2, 3, 1, "wr_wfirst");
    check_eq("merge_model", ref_mem[16], 32'hDE22_BE44);
    do_read(32'h0000_0040, 0, "rd_merge");
    do_read(32'h0002_0040, 0, "rd_alias1");
    do_read(32'hF000_0041, 10, "rd_alias2_hold");

    // Write commit lands on the same edge as the fetch of the same word
    v_old = ref_mem[16];
    v_new = 32'hA5A5_0F0F;
    araddr = 32'h0000_0040; arvalid = 1'b1;
    check_eq("col_arready", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    awaddr = 32'h0000_0040; wdata = v_new; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    check_eq("col_awready", {31'd0, awready & wready}, 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("col_bvalid", {31'd0, bvalid}, 32'd1);
    tick();
    check_eq("col_rvalid", {31'd0, rvalid}, 32'd1);
    check_eq("col_rdata_old", rdata, v_old);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    ref_mem[16] = v_new;
    do_read(32'h0000_0040, 0, "col_rd_new");

    for (int i = 0; i < 32; i++) begin
      do_write(32'(i) << 2, $urandom, 4'hF, 0, 0, 0, "init_wr");
    end

    // Reset while holding only the address half of a write
    v_old = ref_mem[17];
    awaddr = 32'h0000_0044; awvalid = 1'b1;
    wait_rdy(0, "rst_mid");
    tick();
    awvalid = 1'b0;
    check_eq("rst_mid_have_a", {31'd0, wready & ~awready}, 32'd1);
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1; reset = 1'b1;
    tick();
    check_eq("rst_mid_outs", {26'd0, awready, wready, bvalid, arready, rvalid, 1'b0}, 32'd0);
    check_eq("rst_mid_rdata", rdata, 32'd0);
    reset = 1'b0; wvalid = 1'b0;
    tick();
    check_eq("rst_mid_readies", {30'd0, awready, wready}, 32'd3);
    check_eq("rst_mid_bvalid", {31'd0, bvalid}, 32'd0);
    check_eq("rst_mid_model", ref_mem[17], v_old);
    do_read(32'h0000_0044, 0, "rst_mid_unchanged");

    for (int i = 0; i < 80; i++) begin
      a = ($urandom & ~32'h0001_FFFC) | (32'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                 $urandom_range(0, 3), "rnd_wr");
      end else begin
        do_read(a, $urandom_range(0, 3), "rnd_rd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
